pipeline_hazard_controller: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipelined RISC-V core. It takes decoded control bits from ID, EX and MEM (the outputs of the decode control unit, as carried down the pipeline registers) plus the data-memory handshake. From these it generates the write-enable, flush and PC-select signals for the PC and the four pipeline registers. It also runs a memory-wait/timeout state machine and keeps saturating performance counters for stalls, flushes and memory-wait cycles.

---
 rtl/pipeline_hazard_controller_pkg.sv | 16 +
 rtl/saturating_counter.sv | 35 +++
 rtl/pipeline_hazard_controller.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hazardState_t : controller FSM state (2-bit encoding)
//   DEFAULT_*     : default parameter values used by the controller
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazardState_t;

    localparam int unsigned DEFAULT_REG_ADDR_WIDTH = 5;
    localparam int unsigned DEFAULT_COUNTER_WIDTH  = 32;
    localparam int unsigned DEFAULT_MEM_TIMEOUT    = 255;

endpackage

// File: rtl/saturating_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous active-high clear
//   increment : add one this cycle (ignored once saturated)
//   value     : current count
module saturating_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             increment,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (increment && (value_q != '1)) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing controller for the 5-stage RISC-V pipeline.
// Generates PC / pipeline-register enables, flushes and PC select from the
// ID/EX/MEM control bits and the data-memory handshake. Runs a memory-wait
// FSM with timeout into a sticky ERROR state, and keeps saturating counters.
// Ports:
//   clock, reset                     : clock, synchronous active-high reset
//   idRs1/idRs2, idUsesRs1/idUsesRs2 : sources read by the ID instruction
//   exRd, exMemoryReadEnable         : destination and load flag of EX
//   exBranchTaken                    : redirect resolved in EX
//   memRequest, memReady             : data-memory handshake of MEM
//   *WriteEnable, *Flush, memWbBubble, pcSelectBranch : pipeline controls
//   memTimeoutError                  : set while in ERROR
//   stallCount, flushCount, memWaitCount : performance counters
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int unsigned COUNTER_WIDTH  = DEFAULT_COUNTER_WIDTH,
    parameter int unsigned MEM_TIMEOUT    = DEFAULT_MEM_TIMEOUT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] idRs1,
    input  logic [REG_ADDR_WIDTH-1:0] idRs2,
    input  logic                      idUsesRs1,
    input  logic                      idUsesRs2,
    input  logic [REG_ADDR_WIDTH-1:0] exRd,
    input  logic                      exMemoryReadEnable,
    input  logic                      exBranchTaken,
    input  logic                      memRequest,
    input  logic                      memReady,
    output logic                      pcWriteEnable,
    output logic                      ifIdWriteEnable,
    output logic                      idExWriteEnable,
    output logic                      exMemWriteEnable,
    output logic                      ifIdFlush,
    output logic                      idExFlush,
    output logic                      memWbBubble,
    output logic                      pcSelectBranch,
    output logic                      memTimeoutError,
    output logic [COUNTER_WIDTH-1:0]  stallCount,
    output logic [COUNTER_WIDTH-1:0]  flushCount,
    output logic [COUNTER_WIDTH-1:0]  memWaitCount
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    hazardState_t     state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

    logic freeze, load_use;
    logic inc_stall, inc_flush, inc_wait;

    assign freeze   = memRequest && !memReady;
    assign load_use = exMemoryReadEnable && (exRd != '0) &&
                      ((idUsesRs1 && (idRs1 == exRd)) || (idUsesRs2 && (idRs2 == exRd)));

    always_comb begin
        pcWriteEnable    = 1'b0;
        ifIdWriteEnable  = 1'b0;
        idExWriteEnable  = 1'b0;
        exMemWriteEnable = 1'b0;
        ifIdFlush        = 1'b0;
        idExFlush        = 1'b0;
        memWbBubble      = 1'b0;
        pcSelectBranch   = 1'b0;
        memTimeoutError  = 1'b0;
        inc_stall        = 1'b0;
        inc_flush        = 1'b0;
        inc_wait         = 1'b0;
        state_d          = state_q;
        wait_cnt_d       = wait_cnt_q;

        if (reset) begin
            state_d    = RUN;
            wait_cnt_d = '0;
        end else if (state_q == ERROR) begin
            memWbBubble     = 1'b1;
            memTimeoutError = 1'b1;
        end else begin
            // Priority: memory freeze > branch flush > load-use stall.
            if (freeze) begin
                memWbBubble = 1'b1;
                inc_wait    = 1'b1;
            end else begin
                pcWriteEnable    = 1'b1;
                ifIdWriteEnable  = 1'b1;
                idExWriteEnable  = 1'b1;
                exMemWriteEnable = 1'b1;
                if (exBranchTaken) begin
                    pcSelectBranch = 1'b1;
                    ifIdFlush      = 1'b1;
                    idExFlush      = 1'b1;
                    inc_flush      = 1'b1;
                end else if (load_use) begin
                    pcWriteEnable   = 1'b0;
                    ifIdWriteEnable = 1'b0;
                    idExFlush       = 1'b1;
                    inc_stall       = 1'b1;
                end
            end

            unique case (state_q)
                RUN: begin
                    if (freeze) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WaitW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (memReady) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == WaitW'(MEM_TIMEOUT)) begin
                        state_d = ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WaitW'(1);
                    end
                end
                default: begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_counter (
        .clock     (clock),
        .reset     (reset),
        .increment (inc_stall),
        .value     (stallCount)
    );

    saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_counter (
        .clock     (clock),
        .reset     (reset),
        .increment (inc_flush),
        .value     (flushCount)
    );

    saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_wait_counter (
        .clock     (clock),
        .reset     (reset),
        .increment (inc_wait),
        .value     (memWaitCount)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized self-checking bench for pipeline_hazard_controller with a
// behavioural reference model (plain flags and integer counts).
module tb_pipeline_hazard_controller;

    localparam int unsigned RW   = 5;
    localparam int unsigned CW   = 4;
    localparam int unsigned TO   = 4;
    localparam int          MAXC = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [RW-1:0] idRs1, idRs2, exRd;
    logic          idUsesRs1, idUsesRs2, exMemoryReadEnable, exBranchTaken;
    logic          memRequest, memReady;
    logic          pcWriteEnable, ifIdWriteEnable, idExWriteEnable, exMemWriteEnable;
    logic          ifIdFlush, idExFlush, memWbBubble, pcSelectBranch, memTimeoutError;
    logic [CW-1:0] stallCount, flushCount, memWaitCount;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_waiting, m_error;
    int m_wait_cycles;
    int m_stall, m_flush, m_mw;

    always #5 clock = ~clock;

    pipeline_hazard_controller #(
        .REG_ADDR_WIDTH (RW),
        .COUNTER_WIDTH  (CW),
        .MEM_TIMEOUT    (TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .idRs1              (idRs1),
        .idRs2              (idRs2),
        .idUsesRs1          (idUsesRs1),
        .idUsesRs2          (idUsesRs2),
        .exRd               (exRd),
        .exMemoryReadEnable (exMemoryReadEnable),
        .exBranchTaken      (exBranchTaken),
        .memRequest         (memRequest),
        .memReady           (memReady),
        .pcWriteEnable      (pcWriteEnable),
        .ifIdWriteEnable    (ifIdWriteEnable),
        .idExWriteEnable    (idExWriteEnable),
        .exMemWriteEnable   (exMemWriteEnable),
        .ifIdFlush          (ifIdFlush),
        .idExFlush          (idExFlush),
        .memWbBubble        (memWbBubble),
        .pcSelectBranch     (pcSelectBranch),
        .memTimeoutError    (memTimeoutError),
        .stallCount         (stallCount),
        .flushCount         (flushCount),
        .memWaitCount       (memWaitCount)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit lu_hit();
        return exMemoryReadEnable && (exRd != 0) &&
               ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
    endfunction

    function automatic bit frozen();
        return memRequest && !memReady;
    endfunction

    // {pcWE, ifIdWE, idExWE, exMemWE, ifIdFlush, idExFlush, bubble, pcSel, err}
    function automatic logic [8:0] exp_ctrl();
        if (reset)          return 9'b000_000_000;
        if (m_error)        return 9'b000_000_101;
        if (frozen())       return 9'b000_000_100;
        if (exBranchTaken)  return 9'b111_111_010;
        if (lu_hit())       return 9'b001_101_000;
        return 9'b111_100_000;
    endfunction

    task automatic model_update();
        if (reset) begin
            m_waiting = 0; m_error = 0; m_wait_cycles = 0;
            m_stall = 0; m_flush = 0; m_mw = 0;
        end else if (!m_error) begin
            if (frozen()) m_mw = (m_mw < MAXC) ? m_mw + 1 : m_mw;
            else if (exBranchTaken) m_flush = (m_flush < MAXC) ? m_flush + 1 : m_flush;
            else if (lu_hit()) m_stall = (m_stall < MAXC) ? m_stall + 1 : m_stall;

            if (!m_waiting) begin
                if (frozen()) begin
                    m_waiting = 1; m_wait_cycles = 1;
                end
            end else if (memReady) begin
                m_waiting = 0; m_wait_cycles = 0;
            end else if (m_wait_cycles == TO) begin
                m_waiting = 0; m_error = 1;
            end else begin
                m_wait_cycles++;
            end
        end
    endtask

    // Entered at posedge+1 with inputs already driven; leaves at next posedge+1.
    task automatic do_cycle();
        #3;
        check_eq("ctrl", {pcWriteEnable, ifIdWriteEnable, idExWriteEnable, exMemWriteEnable,
                          ifIdFlush, idExFlush, memWbBubble, pcSelectBranch, memTimeoutError},
                 exp_ctrl());
        @(posedge clock);
        model_update();
        #1;
        check_eq("stallCount", 32'(stallCount), m_stall);
        check_eq("flushCount", 32'(flushCount), m_flush);
        check_eq("memWaitCount", 32'(memWaitCount), m_mw);
    endtask

    task automatic idle_inputs();
        reset = 0; idRs1 = 0; idRs2 = 0; exRd = 0;
        idUsesRs1 = 0; idUsesRs2 = 0; exMemoryReadEnable = 0; exBranchTaken = 0;
        memRequest = 0; memReady = 0;
    endtask

    int ready_pct;

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clock); #1;
        do_cycle();
        reset = 0;
        check_eq("rst_err", 32'(memTimeoutError), 0);

        // Load-use on rs1 -> one stall
        exMemoryReadEnable = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1;
        do_cycle();
        check_eq("lu_stall", 32'(stallCount), 1);

        // x0 destination and unused source -> no stall
        exRd = 0; idRs1 = 0;
        do_cycle();
        exRd = 5; idRs1 = 5; idUsesRs1 = 0;
        do_cycle();
        check_eq("no_stall", 32'(stallCount), 1);

        // Branch beats load-use
        idUsesRs1 = 1; exBranchTaken = 1;
        #3;
        check_eq("br_pcsel", 32'(pcSelectBranch), 1);
        check_eq("br_pcwe", 32'(pcWriteEnable), 1);
        #(-3 + 3);
        @(posedge clock); model_update(); #1;
        check_eq("br_flush", 32'(flushCount), 1);
        check_eq("br_stall", 32'(stallCount), 1);

        // Held branch across a 3-cycle memory freeze
        idle_inputs();
        exBranchTaken = 1; memRequest = 1; memReady = 0;
        repeat (3) do_cycle();
        memReady = 1;
        do_cycle();
        check_eq("mw_count", 32'(memWaitCount), 3);
        check_eq("mw_flush", 32'(flushCount), 2);

        // Timeout into ERROR, then reset
        idle_inputs();
        memRequest = 1; memReady = 0;
        repeat (6) do_cycle();
        check_eq("to_err", 32'(memTimeoutError), 1);
        check_eq("to_pcwe", 32'(pcWriteEnable), 0);
        reset = 1;
        do_cycle();
        reset = 0;
        check_eq("to_rst_err", 32'(memTimeoutError), 0);
        check_eq("to_rst_mw", 32'(memWaitCount), 0);

        // Saturation of flushCount
        idle_inputs();
        exBranchTaken = 1;
        repeat (20) do_cycle();
        check_eq("sat_flush", 32'(flushCount), MAXC);

        // Randomized phase
        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) ready_pct = (i / 200) % 3 == 0 ? 10 : ((i / 200) % 3 == 1 ? 50 : 90);
            reset              = ($urandom_range(0, 59) == 0);
            idRs1              = RW'($urandom_range(0, 3));
            idRs2              = RW'($urandom_range(0, 3));
            exRd               = RW'($urandom_range(0, 3));
            idUsesRs1          = 1'($urandom_range(0, 1));
            idUsesRs2          = 1'($urandom_range(0, 1));
            exMemoryReadEnable = 1'($urandom_range(0, 1));
            exBranchTaken      = ($urandom_range(0, 3) == 0);
            memRequest         = 1'($urandom_range(0, 1));
            memReady           = ($urandom_range(0, 99) < ready_pct);
            do_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
